pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Control block between instruction decode, the interrupt source and the ez8 program counter. It arbitrates flow-change requests (goto/call/ret/skip) against interrupt entry and issues single-cycle command pulses to the PC. It runs the interrupt entry sequence (wait, save accumulator, vector) and tracks return-stack depth to detect overflow and underflow. Fatal errors halt the core until reset.

Parameters:
STACK_DEPTH, 8, maximum nesting of call plus interrupt entries the PC return stack holds.
DW, $clog2(STACK_DEPTH+1), width of the depth counter; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
pause  in  1  global stall; freezes the sequencer.
kill  in  1  from PC: the current decode slot is flushed, so its request is ignored.
dec_goto  in  1  decode requests a goto.
dec_call  in  1  decode requests a call.
dec_ret  in  1  decode requests a return (also exits the ISR).
dec_skip  in  1  decode requests a skip of the next instruction.
dec_addr  in  12  target for goto/call.
irq_req  in  1  level interrupt request.
irq_ack  out  1  one-cycle pulse when the vector is issued.
goto  out  1  PC command pulse.
goto_addr  out  12  target, valid with goto/call; holds its last value otherwise.
call  out  1  PC command pulse.
ret  out  1  PC command pulse.
skip  out  1  PC command pulse.
interrupt  out  1  PC vector command pulse.
save_accum  out  1  accumulator save pulse.
in_isr  out  1  handler active; masks irq_req.
stack_depth  out  DW  current return-stack occupancy.
error  out  1  sticky fatal error.
err_code  out  2  01 overflow, 10 underflow, 11 multiple requests, 00 none.
stopped  out  1  core halted; sticky.

Behaviour:
- Reset (async): all outputs are 0, goto_addr=12'h0, stack_depth=0, state=RUN.
- Every output is registered. A request sampled at edge N produces its pulse in the cycle after edge N, so latency is 1 cycle. Each command pulse lasts exactly 1 cycle.
- States: RUN, INT_SAVE, INT_VEC, HALT.
- Priority at each edge: reset > HALT > pause > kill > decode request > interrupt.
- pause=1: all command pulses and irq_ack are 0. State, depth, in_isr and goto_addr hold. Requests in that cycle are discarded; irq_req is level and is re-sampled later.
- kill=1 (not paused): dec_* are ignored and no pulse is issued. irq_req is still eligible.
- RUN with exactly one dec_* asserted:
  - goto: goto=1, goto_addr=dec_addr.
  - call: call=1, goto_addr=dec_addr, depth+1.
  - ret: ret=1, depth-1, in_isr cleared.
  - skip: skip=1.
- More than one dec_* at once -> error=1, err_code=11, HALT, no pulse.
- call at depth==STACK_DEPTH -> error, err_code=01, HALT, no pulse.
- ret at depth==0 -> error, err_code=10, HALT, no pulse.
- Interrupt entry: taken in RUN when irq_req=1, in_isr=0, no valid dec request, and not paused.
  - A decode request in the same cycle wins; the interrupt is deferred to the next eligible cycle.
  - Entry edge: state -> INT_SAVE and save_accum=1 for 1 cycle.
  - Next edge: if depth==STACK_DEPTH, then error/err_code=01/HALT. Otherwise state -> INT_VEC; interrupt=1 and irq_ack=1 for 1 cycle; depth+1; in_isr=1.
  - Following edge: state -> RUN.
  - In INT_SAVE/INT_VEC, dec_* requests are ignored; decode is flushed by the PC.
- Pause during INT_SAVE/INT_VEC: the state holds and the pending step's pulse is issued on the first unpaused edge.
- HALT: stopped=1 from the error edge; error and err_code hold; no pulses; leaves only on reset.
- Reset mid-sequence: aborts immediately with no pulse.

Test Plan:
- Reset, then dec_goto with dec_addr=12'h0A5 -> next cycle goto=1, goto_addr=0x0A5; depth stays 0; goto=0 on the following cycle.
- 8 consecutive dec_call, then a 9th dec_call -> depth steps 1..8; 9th: no call pulse, error=1, err_code=01, stopped=1.
- dec_ret at depth 0 after reset -> no ret pulse, err_code=10, stopped=1; reset clears all.
- irq_req=1 with dec_call in the same cycle -> call pulse first; then save_accum, then interrupt+irq_ack on consecutive cycles; depth=2; in_isr=1; further irq_req ignored until dec_ret clears in_isr.
- pause=1 asserted while in INT_SAVE for 3 cycles -> no pulses during pause; interrupt issues 1 cycle after pause drops.
- dec_goto and dec_skip asserted together -> err_code=11, HALT. Separately: dec_call with kill=1 -> no pulse, depth unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: arbitrates decode flow-change requests against interrupt entry,
// issues single-cycle command pulses to the program counter, runs the
// interrupt entry sequence (save accumulator, then vector) and tracks
// return-stack depth so that overflow and underflow halt the core.
module pc_sequencer #(
    parameter int unsigned STACK_DEPTH = 8,
    localparam int unsigned DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pause,
    input  logic          kill,
    input  logic          dec_goto,
    input  logic          dec_call,
    input  logic          dec_ret,
    input  logic          dec_skip,
    input  logic [11:0]   dec_addr,
    input  logic          irq_req,
    output logic          irq_ack,
    output logic          goto,
    output logic [11:0]   goto_addr,
    output logic          call,
    output logic          ret,
    output logic          skip,
    output logic          interrupt,
    output logic          save_accum,
    output logic          in_isr,
    output logic [DW-1:0] stack_depth,
    output logic          error,
    output logic [1:0]    err_code,
    output logic          stopped
);

    typedef enum logic [1:0] {
        StRun,
        StIntSave,
        StIntVec,
        StHalt
    } state_e;

    localparam logic [DW-1:0] MaxDepth = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DepthOne = DW'(1);

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrOverflow = 2'b01;
    localparam logic [1:0] ErrUnderflw = 2'b10;
    localparam logic [1:0] ErrMulti    = 2'b11;

    state_e        state_q, state_d;

    logic          goto_q, goto_d;
    logic          call_q, call_d;
    logic          ret_q, ret_d;
    logic          skip_q, skip_d;
    logic          interrupt_q, interrupt_d;
    logic          save_accum_q, save_accum_d;
    logic          irq_ack_q, irq_ack_d;

    logic [11:0]   goto_addr_q, goto_addr_d;
    logic          in_isr_q, in_isr_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          error_q, error_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          stopped_q, stopped_d;

    logic [3:0]    dec_vec;
    logic          dec_any;
    logic          dec_multi;
    logic          depth_full;
    logic          depth_empty;
    logic          irq_eligible;

    // Request qualification: kill flushes the decode slot, so its requests vanish.
    always_comb begin
        dec_vec      = {dec_goto, dec_call, dec_ret, dec_skip};
        // More than one bit set iff clearing the lowest set bit leaves something.
        dec_multi    = !kill && ((dec_vec & (dec_vec - 4'd1)) != 4'd0);
        dec_any      = !kill && (dec_vec != 4'd0);
        depth_full   = (depth_q == MaxDepth);
        depth_empty  = (depth_q == '0);
        irq_eligible = irq_req && !in_isr_q;
    end

    // Next-state and next-output logic; pulses default low, status defaults to hold.
    always_comb begin
        state_d      = state_q;
        goto_d       = 1'b0;
        call_d       = 1'b0;
        ret_d        = 1'b0;
        skip_d       = 1'b0;
        interrupt_d  = 1'b0;
        save_accum_d = 1'b0;
        irq_ack_d    = 1'b0;
        goto_addr_d  = goto_addr_q;
        in_isr_d     = in_isr_q;
        depth_d      = depth_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        stopped_d    = stopped_q;

        unique case (state_q)
            StRun: begin
                if (!pause) begin
                    if (dec_multi) begin
                        state_d    = StHalt;
                        error_d    = 1'b1;
                        err_code_d = ErrMulti;
                        stopped_d  = 1'b1;
                    end else if (dec_any) begin
                        // Exactly one request is present here.
                        if (dec_goto) begin
                            goto_d      = 1'b1;
                            goto_addr_d = dec_addr;
                        end else if (dec_call) begin
                            if (depth_full) begin
                                state_d    = StHalt;
                                error_d    = 1'b1;
                                err_code_d = ErrOverflow;
                                stopped_d  = 1'b1;
                            end else begin
                                call_d      = 1'b1;
                                goto_addr_d = dec_addr;
                                depth_d     = depth_q + DepthOne;
                            end
                        end else if (dec_ret) begin
                            if (depth_empty) begin
                                state_d    = StHalt;
                                error_d    = 1'b1;
                                err_code_d = ErrUnderflw;
                                stopped_d  = 1'b1;
                            end else begin
                                ret_d    = 1'b1;
                                depth_d  = depth_q - DepthOne;
                                in_isr_d = 1'b0;
                            end
                        end else begin
                            skip_d = 1'b1;
                        end
                    end else if (irq_eligible) begin
                        // A decode request in the same cycle wins; irq waits.
                        state_d      = StIntSave;
                        save_accum_d = 1'b1;
                    end
                end
            end

            StIntSave: begin
                if (!pause) begin
                    if (depth_full) begin
                        state_d    = StHalt;
                        error_d    = 1'b1;
                        err_code_d = ErrOverflow;
                        stopped_d  = 1'b1;
                    end else begin
                        state_d     = StIntVec;
                        interrupt_d = 1'b1;
                        irq_ack_d   = 1'b1;
                        depth_d     = depth_q + DepthOne;
                        in_isr_d    = 1'b1;
                    end
                end
            end

            StIntVec: begin
                if (!pause) begin
                    state_d = StRun;
                end
            end

            StHalt: begin
                // Sticky until reset; nothing moves.
                state_d = StHalt;
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Sequencer state and sticky status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            goto_addr_q <= 12'h000;
            in_isr_q    <= 1'b0;
            depth_q     <= '0;
            error_q     <= 1'b0;
            err_code_q  <= ErrNone;
            stopped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            goto_addr_q <= goto_addr_d;
            in_isr_q    <= in_isr_d;
            depth_q     <= depth_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            stopped_q   <= stopped_d;
        end
    end

    // Single-cycle command pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            goto_q       <= 1'b0;
            call_q       <= 1'b0;
            ret_q        <= 1'b0;
            skip_q       <= 1'b0;
            interrupt_q  <= 1'b0;
            save_accum_q <= 1'b0;
            irq_ack_q    <= 1'b0;
        end else begin
            goto_q       <= goto_d;
            call_q       <= call_d;
            ret_q        <= ret_d;
            skip_q       <= skip_d;
            interrupt_q  <= interrupt_d;
            save_accum_q <= save_accum_d;
            irq_ack_q    <= irq_ack_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        goto        = goto_q;
        call        = call_q;
        ret         = ret_q;
        skip        = skip_q;
        interrupt   = interrupt_q;
        save_accum  = save_accum_q;
        irq_ack     = irq_ack_q;
        goto_addr   = goto_addr_q;
        in_isr      = in_isr_q;
        stack_depth = depth_q;
        error       = error_q;
        err_code    = err_code_q;
        stopped     = stopped_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        pause;
    logic        kill;
    logic        dec_goto;
    logic        dec_call;
    logic        dec_ret;
    logic        dec_skip;
    logic [11:0] dec_addr;
    logic        irq_req;
    logic        irq_ack;
    logic        goto;
    logic [11:0] goto_addr;
    logic        call;
    logic        ret;
    logic        skip;
    logic        interrupt;
    logic        save_accum;
    logic        in_isr;
    logic [3:0]  stack_depth;
    logic        error;
    logic [1:0]  err_code;
    logic        stopped;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(.STACK_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .kill       (kill),
        .dec_goto   (dec_goto),
        .dec_call   (dec_call),
        .dec_ret    (dec_ret),
        .dec_skip   (dec_skip),
        .dec_addr   (dec_addr),
        .irq_req    (irq_req),
        .irq_ack    (irq_ack),
        .goto       (goto),
        .goto_addr  (goto_addr),
        .call       (call),
        .ret        (ret),
        .skip       (skip),
        .interrupt  (interrupt),
        .save_accum (save_accum),
        .in_isr     (in_isr),
        .stack_depth(stack_depth),
        .error      (error),
        .err_code   (err_code),
        .stopped    (stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pause    = 1'b0;
        kill     = 1'b0;
        dec_goto = 1'b0;
        dec_call = 1'b0;
        dec_ret  = 1'b0;
        dec_skip = 1'b0;
        irq_req  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Pulse vector order: goto call ret skip interrupt save_accum irq_ack
    function automatic logic [31:0] pulses();
        return 32'({goto, call, ret, skip, interrupt, save_accum, irq_ack});
    endfunction

    initial begin
        dec_addr = 12'h000;
        reset    = 1'b0;
        idle();
        #2;
        do_reset();

        // Reset state
        check("rst_pulses", pulses(), 0);
        check("rst_addr", 32'(goto_addr), 0);
        check("rst_depth", 32'(stack_depth), 0);
        check("rst_status", 32'({in_isr, error, err_code, stopped}), 0);

        // goto
        dec_goto = 1'b1;
        dec_addr = 12'h0A5;
        tick();
        dec_goto = 1'b0;
        check("goto_pulse", pulses(), 32'b1000000);
        check("goto_addr", 32'(goto_addr), 32'h0A5);
        check("goto_depth", 32'(stack_depth), 0);
        tick();
        check("goto_end", 32'(goto), 0);
        check("goto_addr_hold", 32'(goto_addr), 32'h0A5);

        // Eight calls fill the stack; the ninth overflows.
        dec_call = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dec_addr = 12'h100 + 12'(i);
            tick();
            check("call_pulse", 32'(call), 1);
            check("call_depth", 32'(stack_depth), 32'(i + 1));
        end
        check("call_addr", 32'(goto_addr), 32'h107);
        dec_addr = 12'h1FF;
        tick();
        dec_call = 1'b0;
        check("ovf_no_call", pulses(), 0);
        check("ovf_status", 32'({error, err_code, stopped}), 32'b1011);
        check("ovf_depth", 32'(stack_depth), 8);
        dec_goto = 1'b1;
        tick();
        dec_goto = 1'b0;
        check("halt_no_goto", pulses(), 0);
        check("halt_sticky", 32'({error, err_code, stopped}), 32'b1011);

        // ret at depth 0 underflows.
        do_reset();
        dec_ret = 1'b1;
        tick();
        dec_ret = 1'b0;
        check("unf_no_ret", pulses(), 0);
        check("unf_status", 32'({error, err_code, stopped}), 32'b1101);
        do_reset();
        check("rst_clears", 32'({error, err_code, stopped, stack_depth}), 0);

        // irq together with call: call wins, then the entry sequence.
        irq_req  = 1'b1;
        dec_call = 1'b1;
        dec_addr = 12'h200;
        tick();
        dec_call = 1'b0;
        check("irqcall_call", pulses(), 32'b0100000);
        check("irqcall_depth", 32'(stack_depth), 1);
        tick();
        check("irq_save", pulses(), 32'b0000010);
        tick();
        check("irq_vec", pulses(), 32'b0000101);
        check("irq_depth", 32'(stack_depth), 2);
        check("irq_in_isr", 32'(in_isr), 1);
        tick();
        check("irq_back_run", pulses(), 0);
        tick();
        check("irq_masked", pulses(), 0);
        dec_ret = 1'b1;
        tick();
        dec_ret = 1'b0;
        check("isr_ret", pulses(), 32'b0010000);
        check("isr_ret_depth", 32'(stack_depth), 1);
        check("isr_ret_clr", 32'(in_isr), 0);
        tick();
        check("irq_reenter", pulses(), 32'b0000010);

        // Pause for three cycles while in the save step.
        pause   = 1'b1;
        irq_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_quiet", pulses(), 0);
            check("pause_depth", 32'(stack_depth), 1);
        end
        pause = 1'b0;
        tick();
        check("unpause_vec", pulses(), 32'b0000101);
        check("unpause_depth", 32'(stack_depth), 2);
        tick();
        check("unpause_end", pulses(), 0);

        // Multiple simultaneous requests.
        do_reset();
        dec_goto = 1'b1;
        dec_skip = 1'b1;
        tick();
        idle();
        check("multi_no_pulse", pulses(), 0);
        check("multi_status", 32'({error, err_code, stopped}), 32'b1111);

        // kill suppresses a call; a later plain skip still works.
        do_reset();
        kill     = 1'b1;
        dec_call = 1'b1;
        tick();
        idle();
        check("kill_no_call", pulses(), 0);
        check("kill_depth", 32'(stack_depth), 0);
        check("kill_no_err", 32'(error), 0);
        dec_skip = 1'b1;
        tick();
        dec_skip = 1'b0;
        check("skip_pulse", pulses(), 32'b0001000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
